// File: rtl/target_scheduler.sv
// Target scheduler: snapshots 16 region detections per frame, scans them for the
// detection nearest the screen centre (with a sticky lock), and issues a deadzoned
// pointing error to the motor controller over a valid/ready handshake.
// Region i of aim_x_all / aim_y_all occupies bits [i*10 +: 10].
module target_scheduler #(
   parameter int unsigned CX          = 320,
   parameter int unsigned CY          = 240,
   parameter int unsigned DEADZONE    = 8,
   parameter int unsigned LOST_FRAMES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_update,
   input  logic [15:0]        aim_detected_all,
   input  logic [159:0]       aim_x_all,
   input  logic [159:0]       aim_y_all,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic signed [10:0] cmd_dx,
   output logic signed [10:0] cmd_dy,
   output logic [3:0]         lock_idx,
   output logic               lock_valid,
   output logic               target_lost,
   output logic               busy
);

   localparam int unsigned      LostW   = (LOST_FRAMES < 1) ? 1 : $clog2(LOST_FRAMES + 1);
   localparam logic [10:0]      CxW     = 11'(CX);
   localparam logic [10:0]      CyW     = 11'(CY);
   localparam logic [10:0]      DzW     = 11'(DEADZONE);
   localparam logic [LostW-1:0] LostMax = LostW'(LOST_FRAMES);

   typedef enum logic [1:0] {StIdle, StScan, StDecide, StIssue} state_e;

   // |v - c| as an 11-bit unsigned magnitude
   function automatic logic [10:0] abs_dist(input logic [9:0] v, input logic [10:0] c);
      logic signed [11:0] d;
      d = $signed({2'b00, v}) - $signed({1'b0, c});
      return d[11] ? 11'(-d) : d[10:0];
   endfunction

   // Signed v - c, forced to zero inside the deadzone
   function automatic logic signed [10:0] axis_err(input logic [9:0] v, input logic [10:0] c);
      logic signed [10:0] d;
      logic [10:0]        mag;
      d   = $signed({1'b0, v}) - $signed(c);
      mag = d[10] ? 11'(-d) : 11'(d);
      return (mag <= DzW) ? 11'sd0 : d;
   endfunction

   state_e             state_q, state_d;
   logic               pending_q, pending_d;
   logic [3:0]         scan_idx_q, scan_idx_d;
   logic [3:0]         best_idx_q, best_idx_d;
   logic [10:0]        best_dist_q, best_dist_d;
   logic               found_q, found_d;
   logic [LostW-1:0]   lost_q, lost_d;
   logic               target_lost_q, target_lost_d;
   logic [3:0]         lock_idx_q, lock_idx_d;
   logic               lock_valid_q, lock_valid_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic signed [10:0] cmd_dx_q, cmd_dx_d;
   logic signed [10:0] cmd_dy_q, cmd_dy_d;
   logic               snap_en;

   logic [15:0]        det_q;
   logic [9:0]         xs_q [16];
   logic [9:0]         ys_q [16];

   logic [10:0]        scan_dist;
   logic               sticky, have_sel;
   logic [3:0]         sel_idx;
   logic signed [10:0] sel_dx, sel_dy;

   // Per-region distance for the region under scan, and the DECIDE selection
   always_comb begin
      scan_dist = abs_dist(xs_q[scan_idx_q], CxW) + abs_dist(ys_q[scan_idx_q], CyW);
      sticky    = lock_valid_q && det_q[lock_idx_q];
      sel_idx   = sticky ? lock_idx_q : best_idx_q;
      have_sel  = sticky || found_q;
      sel_dx    = axis_err(xs_q[sel_idx], CxW);
      sel_dy    = axis_err(ys_q[sel_idx], CyW);
   end

   // Next-state logic for the scheduler FSM and its result registers
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      scan_idx_d    = scan_idx_q;
      best_idx_d    = best_idx_q;
      best_dist_d   = best_dist_q;
      found_d       = found_q;
      lost_d        = lost_q;
      target_lost_d = target_lost_q;
      lock_idx_d    = lock_idx_q;
      lock_valid_d  = lock_valid_q;
      cmd_valid_d   = cmd_valid_q;
      cmd_dx_d      = cmd_dx_q;
      cmd_dy_d      = cmd_dy_q;
      snap_en       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (frame_update || pending_q) begin
               state_d     = StScan;
               pending_d   = 1'b0;
               snap_en     = 1'b1;
               scan_idx_d  = 4'd0;
               found_d     = 1'b0;
               best_idx_d  = 4'd0;
               best_dist_d = '1;
            end
         end
         StScan: begin
            // Strictly smaller wins, so ties keep the lower index
            if (det_q[scan_idx_q] && (!found_q || scan_dist < best_dist_q)) begin
               found_d     = 1'b1;
               best_idx_d  = scan_idx_q;
               best_dist_d = scan_dist;
            end
            scan_idx_d = scan_idx_q + 4'd1;
            if (scan_idx_q == 4'd15) state_d = StDecide;
         end
         StDecide: begin
            state_d = StIdle;
            if (have_sel) begin
               lost_d        = '0;
               target_lost_d = 1'b0;
               lock_idx_d    = sel_idx;
               lock_valid_d  = 1'b1;
               if (sel_dx != 11'sd0 || sel_dy != 11'sd0) begin
                  state_d     = StIssue;
                  cmd_valid_d = 1'b1;
                  cmd_dx_d    = sel_dx;
                  cmd_dy_d    = sel_dy;
               end
            end else begin
               if (lost_q != LostMax) lost_d = lost_q + LostW'(1);
               if (lost_d == LostMax) begin
                  target_lost_d = 1'b1;
                  lock_valid_d  = 1'b0;
               end
            end
         end
         StIssue: begin
            if (cmd_ready) begin
               state_d     = StIdle;
               cmd_valid_d = 1'b0;
               cmd_dx_d    = '0;
               cmd_dy_d    = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      // A frame arriving while busy is remembered once; extra pulses merge
      if (state_q != StIdle && frame_update) pending_d = 1'b1;
   end

   // State and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         pending_q     <= 1'b0;
         scan_idx_q    <= '0;
         best_idx_q    <= '0;
         best_dist_q   <= '0;
         found_q       <= 1'b0;
         lost_q        <= '0;
         target_lost_q <= 1'b0;
         lock_idx_q    <= '0;
         lock_valid_q  <= 1'b0;
         cmd_valid_q   <= 1'b0;
         cmd_dx_q      <= '0;
         cmd_dy_q      <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         scan_idx_q    <= scan_idx_d;
         best_idx_q    <= best_idx_d;
         best_dist_q   <= best_dist_d;
         found_q       <= found_d;
         lost_q        <= lost_d;
         target_lost_q <= target_lost_d;
         lock_idx_q    <= lock_idx_d;
         lock_valid_q  <= lock_valid_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_dx_q      <= cmd_dx_d;
         cmd_dy_q      <= cmd_dy_d;
      end
   end

   // Frame snapshot, captured on the IDLE to SCAN edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         det_q <= '0;
         for (int i = 0; i < 16; i++) begin
            xs_q[i] <= '0;
            ys_q[i] <= '0;
         end
      end else if (snap_en) begin
         det_q <= aim_detected_all;
         for (int i = 0; i < 16; i++) begin
            xs_q[i] <= aim_x_all[i*10 +: 10];
            ys_q[i] <= aim_y_all[i*10 +: 10];
         end
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_dx      = cmd_dx_q;
   assign cmd_dy      = cmd_dy_q;
   assign lock_idx    = lock_idx_q;
   assign lock_valid  = lock_valid_q;
   assign target_lost = target_lost_q;
   assign busy        = (state_q != StIdle);

endmodule
